layer_sched: RTL and testbench

LAYER_SCHED -- requirements
Module: layer_sched

---
 rtl/layer_pkg.sv | 31 +++
 rtl/addr_cnt.sv | 80 ++++++++
 rtl/layer_sched.sv | 138 +++++++++++++
 tb/tb_layer_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : layer_pkg
// Brief    : Shared state encoding, default geometry and width helper for the
//            layer scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package layer_pkg;

  // Scheduler states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  // Default frame geometry
  localparam int LAYERS_DEF = 8;
  localparam int PIXELS_DEF = 64;
  localparam int BPP_DEF    = 3;

  // Fixed output widths
  localparam int ADDR_W = 6;
  localparam int LANES  = 4;

  // Counter width for a wrap value of v, never less than one bit
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr_cnt.sv
`default_nettype none
// ============================================================================
// Module   : addr_cnt
// Brief    : Byte -> pixel -> layer cascade counter. The count outputs show
//            the slot of a byte accepted in the current cycle, so a clear
//            arriving together with an increment is seen as slot zero.
// Revision : 1.0 - initial release
// ============================================================================
module addr_cnt
  import layer_pkg::*;
#(
  parameter int LAYERS = LAYERS_DEF,
  parameter int PIXELS = PIXELS_DEF,
  parameter int BPP    = BPP_DEF,
  parameter int LW     = clog2_min1(LAYERS),
  parameter int PW     = clog2_min1(PIXELS),
  parameter int BW     = clog2_min1(BPP)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [BW-1:0] o_byte,
  output logic [PW-1:0] o_pix,
  output logic [LW-1:0] o_lay,
  output logic          o_last
);

  localparam logic [BW-1:0] C_BYTE_MAX = BW'(BPP - 1);
  localparam logic [PW-1:0] C_PIX_MAX  = PW'(PIXELS - 1);
  localparam logic [LW-1:0] C_LAY_MAX  = LW'(LAYERS - 1);

  logic [BW-1:0] r_byte, w_byte, w_byte_nxt;
  logic [PW-1:0] r_pix,  w_pix,  w_pix_nxt;
  logic [LW-1:0] r_lay,  w_lay,  w_lay_nxt;
  logic          w_byte_end, w_pix_end, w_lay_end;

  // Effective current slot and its successor, wrapping each stage into the next
  always_comb begin
    w_byte     = i_clr ? '0 : r_byte;
    w_pix      = i_clr ? '0 : r_pix;
    w_lay      = i_clr ? '0 : r_lay;
    w_byte_end = (w_byte == C_BYTE_MAX);
    w_pix_end  = (w_pix == C_PIX_MAX);
    w_lay_end  = (w_lay == C_LAY_MAX);
    w_byte_nxt = w_byte_end ? '0 : w_byte + 1'b1;
    w_pix_nxt  = w_pix;
    w_lay_nxt  = w_lay;
    if (w_byte_end) begin
      w_pix_nxt = w_pix_end ? '0 : w_pix + 1'b1;
      if (w_pix_end) begin
        w_lay_nxt = w_lay_end ? '0 : w_lay + 1'b1;
      end
    end
  end

  // Advance on an accepted byte, otherwise honour a pending clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byte <= '0;
      r_pix  <= '0;
      r_lay  <= '0;
    end else if (i_inc) begin
      r_byte <= w_byte_nxt;
      r_pix  <= w_pix_nxt;
      r_lay  <= w_lay_nxt;
    end else if (i_clr) begin
      r_byte <= '0;
      r_pix  <= '0;
      r_lay  <= '0;
    end
  end

  assign o_byte = w_byte;
  assign o_pix  = w_pix;
  assign o_lay  = w_lay;
  assign o_last = w_byte_end && w_pix_end && w_lay_end;

endmodule
`default_nettype wire

// File: rtl/layer_sched.sv
`default_nettype none
// ============================================================================
// Module   : layer_sched
// Brief    : Distributes an incoming byte stream over LAYERS x PIXELS x BPP
//            storage as registered one-hot writes, with frame completion and
//            idle-timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module layer_sched
  import layer_pkg::*;
#(
  parameter int LAYERS  = LAYERS_DEF,
  parameter int PIXELS  = PIXELS_DEF,
  parameter int BPP     = BPP_DEF,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              frame_start_in,
  input  logic              byte_rdy_in,
  input  logic [7:0]        byte_data_in,
  output logic [LAYERS-1:0] layer_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [LANES-1:0]  byte_en_out,
  output logic [7:0]        byte_data_out,
  output logic              frame_rdy_out,
  output logic              busy_out,
  output logic              timeout_out
);

  localparam int LW = clog2_min1(LAYERS);
  localparam int PW = clog2_min1(PIXELS);
  localparam int BW = clog2_min1(BPP);
  localparam int TW = clog2_min1(TIMEOUT + 1);

  state_t            r_state;
  logic [TW-1:0]     r_tmo;
  logic [LAYERS-1:0] r_layer_en;
  logic [ADDR_W-1:0] r_addr;
  logic [LANES-1:0]  r_byte_en;
  logic [7:0]        r_data;
  logic              r_frame_rdy;
  logic              r_timeout;

  logic              w_load, w_accept, w_last, w_tmo_hit;
  logic [TW-1:0]     w_tmo_inc;
  logic [BW-1:0]     w_byte;
  logic [PW-1:0]     w_pix;
  logic [LW-1:0]     w_lay;
  logic [LAYERS-1:0] w_layer_oh;
  logic [LANES-1:0]  w_lane_oh;

  // A frame start makes this cycle a LOAD cycle, so a coincident byte counts
  assign w_load    = frame_start_in || (r_state == ST_LOAD);
  assign w_accept  = byte_rdy_in && w_load;
  assign w_tmo_inc = r_tmo + TW'(1);
  assign w_tmo_hit = (r_state == ST_LOAD) && !frame_start_in && !w_accept &&
                     (w_tmo_inc == TW'(TIMEOUT));

  addr_cnt #(
    .LAYERS (LAYERS),
    .PIXELS (PIXELS),
    .BPP    (BPP)
  ) u_addr_cnt (
    .i_clk   (clk_in),
    .i_rst_n (rst_n_in),
    .i_clr   (frame_start_in),
    .i_inc   (w_accept),
    .o_byte  (w_byte),
    .o_pix   (w_pix),
    .o_lay   (w_lay),
    .o_last  (w_last)
  );

  // Decode the current slot into layer and lane one-hot selects
  always_comb begin
    w_layer_oh = '0;
    w_lane_oh  = '0;
    for (int i = 0; i < LAYERS; i++) begin
      if (w_lay == LW'(i)) w_layer_oh[i] = 1'b1;
    end
    for (int i = 0; i < LANES; i++) begin
      if ((i < BPP) && (w_byte == BW'(i))) w_lane_oh[i] = 1'b1;
    end
  end

  // State, idle timer and the frame_rdy / timeout pulses
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= ST_IDLE;
      r_tmo       <= '0;
      r_frame_rdy <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_frame_rdy <= 1'b0;
      r_timeout   <= 1'b0;
      if (w_accept && w_last) begin
        r_state     <= ST_IDLE;
        r_tmo       <= '0;
        r_frame_rdy <= 1'b1;
      end else if (w_tmo_hit) begin
        r_state   <= ST_IDLE;
        r_tmo     <= '0;
        r_timeout <= 1'b1;
      end else if (w_load) begin
        r_state <= ST_LOAD;
        r_tmo   <= (frame_start_in || w_accept) ? '0 : w_tmo_inc;
      end
    end
  end

  // Registered write port: enables last one cycle, address/data hold
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_layer_en <= '0;
      r_byte_en  <= '0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_layer_en <= w_accept ? w_layer_oh : '0;
      r_byte_en  <= w_accept ? w_lane_oh : '0;
      if (w_accept) begin
        r_addr <= ADDR_W'(w_pix);
        r_data <= byte_data_in;
      end
    end
  end

  assign layer_en_out  = r_layer_en;
  assign wr_addr_out   = r_addr;
  assign byte_en_out   = r_byte_en;
  assign byte_data_out = r_data;
  assign frame_rdy_out = r_frame_rdy;
  assign timeout_out   = r_timeout;
  assign busy_out      = (r_state == ST_LOAD);

endmodule
`default_nettype wire

// File: tb/tb_layer_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_sched
// Brief    : Directed self-checking bench for layer_sched (8x64x3, TIMEOUT=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_sched;

  localparam int NBYTES = 8 * 64 * 3;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       frame_start_in = 1'b0;
  logic       byte_rdy_in = 1'b0;
  logic [7:0] byte_data_in = 8'h00;
  logic [7:0] layer_en_out;
  logic [5:0] wr_addr_out;
  logic [3:0] byte_en_out;
  logic [7:0] byte_data_out;
  logic       frame_rdy_out;
  logic       busy_out;
  logic       timeout_out;

  int n_chk  = 0;
  int n_fail = 0;
  int n_frdy = 0;

  layer_sched #(
    .LAYERS  (8),
    .PIXELS  (64),
    .BPP     (3),
    .TIMEOUT (16)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .frame_start_in (frame_start_in),
    .byte_rdy_in    (byte_rdy_in),
    .byte_data_in   (byte_data_in),
    .layer_en_out   (layer_en_out),
    .wr_addr_out    (wr_addr_out),
    .byte_en_out    (byte_en_out),
    .byte_data_out  (byte_data_out),
    .frame_rdy_out  (frame_rdy_out),
    .busy_out       (busy_out),
    .timeout_out    (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Full observed output word
  function automatic logic [31:0] obs();
    return {3'b000, frame_rdy_out, busy_out, timeout_out, layer_en_out,
            wr_addr_out, byte_en_out, byte_data_out};
  endfunction

  // Control-only view for cycles without a write
  function automatic logic [31:0] ctl();
    return {17'd0, frame_rdy_out, busy_out, timeout_out, layer_en_out, byte_en_out};
  endfunction

  function automatic logic [31:0] wr_word(input bit fr, input bit bz, input int lay,
                                          input int pix, input int byt, input logic [7:0] d);
    logic [7:0] le;
    logic [3:0] be;
    le = 8'h01 << lay;
    be = 4'h1 << byt;
    return {3'b000, fr, bz, 1'b0, le, 6'(pix), be, d};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
    n_frdy += int'(frame_rdy_out);
  endtask

  task automatic start_frame();
    frame_start_in = 1'b1;
    byte_rdy_in    = 1'b0;
    tick();
    frame_start_in = 1'b0;
    check_val("start_ctl", ctl(), {17'd0, 3'b010, 8'h00, 4'h0});
  endtask

  // Stream n back-to-back bytes from slot 0, checking each registered write
  task automatic stream(input int n);
    bit fin;
    for (int k = 0; k < n; k++) begin
      byte_rdy_in  = 1'b1;
      byte_data_in = 8'(k * 7 + 3);
      tick();
      fin = (k == NBYTES - 1);
      check_val($sformatf("wr%0d", k), obs(),
                wr_word(fin, !fin, k / 192, (k / 3) % 64, k % 3, 8'(k * 7 + 3)));
    end
    byte_rdy_in = 1'b0;
  endtask

  initial begin
    // Reset
    tick();
    tick();
    check_val("rst_out", obs(), 32'h0);
    rst_n_in = 1'b1;
    tick();
    check_val("post_rst", obs(), 32'h0);

    // Bytes while IDLE are ignored
    for (int i = 0; i < 5; i++) begin
      byte_rdy_in  = 1'b1;
      byte_data_in = 8'h3C;
      tick();
      check_val("idle_byte", ctl(), 32'h0);
    end
    byte_rdy_in = 1'b0;

    // Full frame back-to-back
    n_frdy = 0;
    start_frame();
    stream(NBYTES);
    check_val("last_le", {24'd0, layer_en_out}, 32'h80);
    check_val("last_addr", {26'd0, wr_addr_out}, 32'd63);
    check_val("last_be", {28'd0, byte_en_out}, 32'h4);
    tick();
    check_val("after_frame", ctl(), 32'h0);
    check_val("frdy_cnt1", n_frdy, 32'd1);

    // Abort after 100 bytes, then a complete frame
    n_frdy = 0;
    start_frame();
    stream(100);
    start_frame();
    stream(NBYTES);
    tick();
    check_val("frdy_cnt2", n_frdy, 32'd1);

    // Frame start coincident with a byte
    frame_start_in = 1'b1;
    byte_rdy_in    = 1'b1;
    byte_data_in   = 8'hA5;
    tick();
    frame_start_in = 1'b0;
    check_val("coinc", obs(), wr_word(1'b0, 1'b1, 0, 0, 0, 8'hA5));

    // Nine more bytes (ten total), then stall into timeout
    for (int k = 1; k < 10; k++) begin
      byte_data_in = 8'(k);
      tick();
      check_val($sformatf("t_wr%0d", k), obs(), wr_word(1'b0, 1'b1, 0, k / 3, k % 3, 8'(k)));
    end
    byte_rdy_in = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_val($sformatf("tmo%0d", i), {30'd0, timeout_out, busy_out},
                {30'd0, (i == 16), (i < 16)});
    end
    for (int i = 0; i < 5; i++) begin
      byte_rdy_in = 1'b1;
      tick();
      check_val("post_tmo", ctl(), 32'h0);
    end
    byte_rdy_in = 1'b0;

    // Reset mid-frame
    n_frdy = 0;
    start_frame();
    stream(50);
    byte_rdy_in = 1'b1;
    #2;
    rst_n_in = 1'b0;
    #1;
    check_val("async_rst", obs(), 32'h0);
    tick();
    tick();
    rst_n_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val("rst_discard", ctl(), 32'h0);
    end
    byte_rdy_in = 1'b0;
    check_val("frdy_cnt3", n_frdy, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // Hard stop in case the main sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
